// File: rtl/icache_refill_pkg.sv
// Shared widths, state encoding and refill constants for the instruction-cache miss handler.
package icache_refill_pkg;

    localparam int unsigned INST_ADDR_W    = 32;
    localparam int unsigned MEM_DATA_W     = 8;
    localparam int unsigned INST_W         = 32;
    localparam int unsigned BYTES_PER_INST = 4;
    localparam int unsigned CNT_W          = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2
    } refill_state_e;

endpackage : icache_refill_pkg

// File: rtl/icache_refill_byte_collector.sv
// Captures returning memory bytes into a little-endian instruction word.
module icache_refill_byte_collector
    import icache_refill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_capture,
    input  logic                  i_clear,
    input  logic [MEM_DATA_W-1:0] i_mem_din,
    output logic [INST_W-1:0]     o_word,
    output logic                  o_done
);

    logic                 r_pend;
    logic [CNT_W-1:0]     r_recv_cnt;
    logic [INST_W-1:0]    r_buf;
    logic                 w_room;

    assign w_room = r_recv_cnt < CNT_W'(BYTES_PER_INST);
    assign o_done = r_pend && (r_recv_cnt == CNT_W'(BYTES_PER_INST - 1));
    assign o_word = r_buf;

    // A grant this cycle means its byte is on i_mem_din next cycle; clear drops any such byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_recv_cnt <= '0;
            r_buf      <= '0;
        end else if (i_clear) begin
            r_pend     <= 1'b0;
            r_recv_cnt <= '0;
        end else begin
            r_pend <= i_capture;
            if (r_pend && w_room) begin
                for (int unsigned b = 0; b < BYTES_PER_INST; b++) begin
                    if (r_recv_cnt == CNT_W'(b)) begin
                        r_buf[b*MEM_DATA_W +: MEM_DATA_W] <= i_mem_din;
                    end
                end
                r_recv_cnt <= r_recv_cnt + CNT_W'(1);
            end
        end
    end

endmodule : icache_refill_byte_collector

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: serves hits, refills misses byte-by-byte and writes the word back.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_W,
    parameter int unsigned MEM_W  = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic              hit_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_grant_i,
    input  logic [MEM_W-1:0]  mem_din_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [INST_W-1:0] winst_o
);

    refill_state_e      r_state;
    refill_state_e      w_state_next;
    logic [ADDR_W-1:0]  r_base;
    logic [CNT_W-1:0]   r_issue_cnt;

    logic               w_kill;
    logic               w_miss;
    logic               w_issue_open;
    logic               w_grant_take;
    logic               w_clear;
    logic               w_done;
    logic [INST_W-1:0]  w_word;

    assign w_kill       = rst || flush_i;
    assign w_miss       = (r_state == ST_IDLE) && req_i && !hit_i && !w_kill;
    assign w_issue_open = r_issue_cnt < CNT_W'(BYTES_PER_INST);
    assign w_grant_take = mem_req_o && mem_grant_i;
    assign w_clear      = w_miss || flush_i;
    assign busy_o       = (r_state != ST_IDLE);

    icache_refill_byte_collector u_collector (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_grant_take),
        .i_clear   (w_clear),
        .i_mem_din (mem_din_i),
        .o_word    (w_word),
        .o_done    (w_done)
    );

    // State register, miss base latch and request issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush_i) begin
                r_issue_cnt <= '0;
            end else if (w_miss) begin
                r_base      <= {pc_i[ADDR_W-1:2], 2'b00};
                r_issue_cnt <= '0;
            end else if (w_grant_take) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and output muxing; reset and flush suppress every strobe for the cycle.
    always_comb begin
        w_state_next = r_state;
        raddr_o      = '0;
        inst_valid_o = 1'b0;
        inst_o       = '0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        we_o         = 1'b0;
        waddr_o      = '0;
        winst_o      = '0;

        unique case (r_state)
            ST_IDLE: begin
                raddr_o = pc_i;
                if (req_i && !w_kill) begin
                    if (hit_i) begin
                        inst_valid_o = 1'b1;
                        inst_o       = inst_i;
                    end else begin
                        w_state_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                raddr_o = r_base;
                if (!w_kill) begin
                    mem_req_o  = w_issue_open;
                    mem_addr_o = r_base + ADDR_W'(r_issue_cnt);
                end
                if (w_done) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The cache forwards this write, so the read port stays on the refilled word.
                raddr_o = r_base;
                if (!w_kill) begin
                    we_o         = 1'b1;
                    waddr_o      = r_base;
                    winst_o      = w_word;
                    inst_valid_o = 1'b1;
                    inst_o       = w_word;
                end
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (flush_i) begin
            w_state_next = ST_IDLE;
        end
    end

endmodule : icache_refill

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: hits, refills with and without grant stalls, flush, reset, wrap.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] raddr_o;
    logic        hit_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i = 1'b0;
    logic [7:0]  mem_din_i = '0;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] winst_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  pend_din = 8'hEE;

    icache_refill dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .raddr_o      (raddr_o),
        .hit_i        (hit_i),
        .inst_i       (inst_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .busy_o       (busy_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_grant_i  (mem_grant_i),
        .mem_din_i    (mem_din_i),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .winst_o      (winst_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 8'h13;
            32'h0000_0201: return 8'h05;
            32'h0000_0202: return 8'hA0;
            32'h0000_0203: return 8'h00;
            32'hFFFF_FFFC: return 8'h93;
            32'hFFFF_FFFD: return 8'h00;
            32'hFFFF_FFFE: return 8'h50;
            32'hFFFF_FFFF: return 8'h00;
            default:       return a[7:0] + 8'h10;
        endcase
    endfunction

    // One cycle: drive inputs after the falling edge, let outputs settle, model the memory reply.
    task automatic drive_cycle(input logic r, input logic rq, input logic [31:0] pc,
                               input logic ht, input logic [31:0] ins,
                               input logic gnt, input logic fl);
        @(negedge clk);
        rst         = r;
        req_i       = rq;
        pc_i        = pc;
        hit_i       = ht;
        inst_i      = ins;
        mem_grant_i = gnt;
        flush_i     = fl;
        mem_din_i   = pend_din;
        #1;
        pend_din = (mem_req_o && mem_grant_i) ? mem_byte(mem_addr_o) : 8'hEE;
    endtask

    // Full miss from detection (cycle 0) through WRITE; grant drops for 'stall' cycles after the 2nd grant.
    task automatic run_miss(input logic [31:0] pc, input int stall, input logic [31:0] word);
        int   issued;
        int   wr_cyc;
        logic g;
        logic exp_req;
        issued = 0;
        wr_cyc = 6 + stall;
        for (int c = 0; c <= wr_cyc; c++) begin
            g = !(c >= 3 && c < 3 + stall);
            drive_cycle(1'b0, 1'b1, pc, 1'b0, 32'hDEAD_BEEF, g, 1'b0);
            exp_req = (c >= 1) && (issued < 4);
            check("busy", 32'(busy_o), 32'(c >= 1));
            check("mem_req", 32'(mem_req_o), 32'(exp_req));
            if (exp_req) check("mem_addr", mem_addr_o, pc + 32'(issued));
            if (exp_req && g) issued++;
            check("we", 32'(we_o), 32'(c == wr_cyc));
            check("inst_valid", 32'(inst_valid_o), 32'(c == wr_cyc));
            if (c == wr_cyc) begin
                check("waddr", waddr_o, pc);
                check("winst", winst_o, word);
                check("inst_o", inst_o, word);
            end
        end
        drive_cycle(1'b0, 1'b0, pc, 1'b0, '0, 1'b1, 1'b0);
        check("idle_after", 32'(busy_o), 32'd0);
    endtask

    initial begin
        drive_cycle(1'b1, 1'b0, 32'h40, 1'b0, '0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 32'h40, 1'b0, '0, 1'b0, 1'b0);

        // Reset state
        drive_cycle(1'b0, 1'b0, 32'h40, 1'b0, '0, 1'b0, 1'b0);
        check("rst_raddr", raddr_o, 32'h40);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_we", 32'(we_o), 32'd0);
        check("rst_ival", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_waddr", waddr_o, 32'd0);
        check("rst_winst", winst_o, 32'd0);

        // Hit, zero latency
        drive_cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h0050_0093, 1'b1, 1'b0);
        check("hit_ival", 32'(inst_valid_o), 32'd1);
        check("hit_inst", inst_o, 32'h0050_0093);
        check("hit_raddr", raddr_o, 32'h100);
        check("hit_mem_req", 32'(mem_req_o), 32'd0);
        check("hit_we", 32'(we_o), 32'd0);

        // Hit with flush is suppressed and stays idle
        drive_cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h0050_0093, 1'b1, 1'b1);
        check("hitfl_ival", 32'(inst_valid_o), 32'd0);
        drive_cycle(1'b0, 1'b0, 32'h100, 1'b0, '0, 1'b1, 1'b0);
        check("hitfl_busy", 32'(busy_o), 32'd0);

        // Miss, grant always high, and with a 2-cycle grant stall
        run_miss(32'h200, 0, 32'h00A0_0513);
        run_miss(32'h200, 2, 32'h00A0_0513);

        // Flush at cycle 3 of a miss; hit at cycle 4 with a stale byte on the bus
        drive_cycle(1'b0, 1'b1, 32'h300, 1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h300, 1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h300, 1'b0, '0, 1'b1, 1'b0);
        check("fl_busy_c2", 32'(busy_o), 32'd1);
        drive_cycle(1'b0, 1'b1, 32'h300, 1'b0, '0, 1'b1, 1'b1);
        check("fl_mem_req", 32'(mem_req_o), 32'd0);
        check("fl_we", 32'(we_o), 32'd0);
        check("fl_ival", 32'(inst_valid_o), 32'd0);
        pend_din = 8'hBB;
        drive_cycle(1'b0, 1'b1, 32'h100, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        check("fl_busy_c4", 32'(busy_o), 32'd0);
        check("fl_hit_ival", 32'(inst_valid_o), 32'd1);
        check("fl_hit_inst", inst_o, 32'h1234_5678);
        check("fl_hit_we", 32'(we_o), 32'd0);
        run_miss(32'h300, 0, 32'h1312_1110);

        // Reset at cycle 2 of a miss
        drive_cycle(1'b0, 1'b1, 32'h404, 1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 32'h404, 1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b1, 32'h404, 1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 32'h404, 1'b0, '0, 1'b1, 1'b0);
        check("rm_busy", 32'(busy_o), 32'd0);
        check("rm_mem_req", 32'(mem_req_o), 32'd0);
        check("rm_mem_addr", mem_addr_o, 32'd0);
        check("rm_we", 32'(we_o), 32'd0);
        check("rm_ival", 32'(inst_valid_o), 32'd0);
        check("rm_raddr", raddr_o, 32'h404);
        run_miss(32'h404, 0, 32'h1716_1514);

        // Address wrap at the top of the space
        run_miss(32'hFFFF_FFFC, 0, 32'h0050_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_icache_refill
